// File: rtl/instr_loader_pkg.sv
// Shared constants for the instruction-memory loader.
// States are plain logic constants so the encoding stays visible on waveforms
// and in any external checker that decodes the state register.
package instr_loader_pkg;

  // Default instruction memory size in bytes.
  localparam int MEM_BYTES_DEFAULT = 128;

  // Default width of the word counter / num_words port.
  localparam int CNT_W_DEFAULT = 6;

  // Bytes per instruction word (big-endian assembly).
  localparam int WORD_BYTES = 4;

  // Loader FSM encoding.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_FLUSH = 3'd2;
  localparam state_t ST_CHECK = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // Fold one byte into a running XOR checksum.
  function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/instr_loader_word_assembler.sv
// Byte-to-word assembler for the instruction loader.
// Bytes are shifted in MSB first, so the first byte of a word ends up in
// bits [31:24]. Only the upper three bytes are stored; the fourth byte is
// taken straight from the input so the completed word is available in the
// same cycle the last byte is accepted, which lets the parent register the
// write without losing a cycle and keeps 1 byte/cycle streaming bubble-free.
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_complete
);

  logic [23:0] shift_q;
  logic [1:0]  byte_cnt;

  // Completed word as it looks once the current byte is shifted in.
  assign word          = {shift_q, byte_in};
  assign word_complete = shift_en && (byte_cnt == 2'd3);

  // Shift register and byte position; clear discards any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q  <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      shift_q  <= '0;
      byte_cnt <= '0;
    end else if (shift_en) begin
      shift_q  <= {shift_q[15:0], byte_in};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Instruction memory loader: writer side of the instruction memory read by
// the single-cycle CPU. A byte stream is assembled into big-endian 32-bit
// words and written at consecutive word-aligned addresses starting at 0.
// The CPU is held (cpu_hold) for the whole load.
//
// Optional feature, macro INSTR_LOADER_CHECKSUM_EN: after the last image
// word one extra byte is accepted and compared against the XOR of all image
// bytes; a mismatch raises load_err together with done. Without the macro
// there is no CHECK state and load_err is tied low.
//
// Handshake: a byte transfers on a rising clock edge where byte_valid and
// byte_ready are both high. byte_ready depends only on state (high in LOAD
// and CHECK), never on byte_valid, so the source may wait on it freely;
// byte_data must be stable while byte_valid is high.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int CNT_W     = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             im_wr_en,
  output logic [31:0]      im_wr_addr,
  output logic [31:0]      im_wr_data,
  output logic             cpu_hold,
  output logic             done,
  output logic             load_err
);

  // Largest image that fits in the memory; requests above it are clamped,
  // which also guarantees the address never wraps.
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(MEM_BYTES / WORD_BYTES);
  localparam logic [31:0]      ADDR_STEP = 32'(WORD_BYTES);

  state_t           state;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] word_cnt;
  logic [31:0]      addr;

  logic             idle_or_done;
  logic             start_load;
  logic             img_xfer;
  logic             last_word;
  logic [CNT_W-1:0] clamped_words;
  logic [31:0]      asm_word;
  logic             asm_complete;

  // Control decode: start is honoured only when no load is in flight.
  assign idle_or_done  = (state == ST_IDLE) || (state == ST_DONE);
  assign start_load    = idle_or_done && start && (num_words != '0);
  assign byte_ready    = (state == ST_LOAD) || (state == ST_CHECK);
  assign img_xfer      = (state == ST_LOAD) && byte_valid;
  assign last_word     = (word_cnt == (target - CNT_W'(1)));
  assign clamped_words = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;

  word_assembler u_word_assembler (
    .clk           (clk),
    .rst           (rst),
    .clear         (start_load),
    .shift_en      (img_xfer),
    .byte_in       (byte_data),
    .word          (asm_word),
    .word_complete (asm_complete)
  );

  // Main FSM plus address, word counter and registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      target     <= '0;
      word_cnt   <= '0;
      addr       <= '0;
      im_wr_en   <= 1'b0;
      im_wr_addr <= '0;
      im_wr_data <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse unless re-armed below.
      im_wr_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (num_words == '0) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state    <= ST_LOAD;
              target   <= clamped_words;
              word_cnt <= '0;
              addr     <= '0;
              done     <= 1'b0;
              cpu_hold <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (asm_complete) begin
            im_wr_en   <= 1'b1;
            im_wr_addr <= addr;
            im_wr_data <= asm_word;
            addr       <= addr + ADDR_STEP;
            word_cnt   <= word_cnt + CNT_W'(1);
            if (last_word) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
              state <= ST_CHECK;
`else
              state <= ST_FLUSH;
`endif
            end
          end
        end
        ST_FLUSH: begin
          // Last write is on the bus this cycle; release the CPU next.
          state    <= ST_DONE;
          done     <= 1'b1;
          cpu_hold <= 1'b0;
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          // First CHECK cycle doubles as the flush of the last word.
          if (byte_valid) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end
        end
`endif
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  // Running XOR of image bytes and the compare against the checksum byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum     <= '0;
      load_err <= 1'b0;
    end else begin
      if (idle_or_done && start) begin
        csum     <= '0;
        load_err <= 1'b0;
      end else if (img_xfer) begin
        csum <= xor_fold(csum, byte_data);
      end else if ((state == ST_CHECK) && byte_valid) begin
        load_err <= (csum != byte_data);
      end
    end
  end
`else
  assign load_err = 1'b0;
`endif

endmodule
